// File: rtl/usb_rx_pkt_if.sv
// Byte stream from ulpi_ctl into the USB packet decoder; error qualifies the tlast beat.
interface usb_rx_pkt_if;
    logic [7:0] tdata;
    logic       tlast;
    logic       error;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tlast, output error, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input error, input tvalid, output tready);
endinterface

// File: rtl/usb_rx_pkt.sv
// USB packet decoder: checks PID and CRC on the ULPI receive stream, classifies packets and
// streams DATA payload with PID and CRC16 stripped. Never back-pressures the PHY.
module usb_rx_pkt #(
    parameter int unsigned MAX_PAYLOAD = 1024
) (
    input  logic        ulpi_clk,
    input  logic        ulpi_rst_n,
    usb_rx_pkt_if.slave axis_rx,
    output logic        token_valid,
    output logic [3:0]  token_pid,
    output logic [6:0]  token_addr,
    output logic [3:0]  token_endp,
    output logic        sof_valid,
    output logic [10:0] sof_frame,
    output logic        hs_valid,
    output logic [3:0]  hs_pid,
    output logic        data_tvalid,
    output logic [7:0]  data_tdata,
    output logic [3:0]  data_pid,
    output logic        data_end,
    output logic        data_ok,
    output logic [10:0] data_len,
    output logic        rx_err,
    output logic [2:0]  rx_err_code
);
    typedef enum logic [2:0] {StIdle, StToken, StHshk, StData, StDataDrop, StDiscard} state_e;

    localparam logic [2:0]  ErrPid       = 3'd1;
    localparam logic [2:0]  ErrCrc5      = 3'd2;
    localparam logic [2:0]  ErrCrc16     = 3'd3;
    localparam logic [2:0]  ErrLen       = 3'd4;
    localparam logic [2:0]  ErrPhy       = 3'd5;
    localparam logic [2:0]  ErrUnsup     = 3'd6;
    localparam logic [15:0] MaxPay       = 16'(MAX_PAYLOAD);
    localparam logic [4:0]  Crc5Residue  = 5'b01100;
    localparam logic [15:0] Crc16Residue = 16'h800D;

    function automatic logic [4:0] crc5_word(input logic [15:0] w);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 16; i++) begin
            if (w[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'b00101;
            else             c = {c[3:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (b[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;      // bytes accepted after the PID
    logic [15:0] crc_q, crc_d;
    logic [7:0]  tok_lo_q, tok_lo_d;
    logic [7:0]  dly0_q, dly0_d, dly1_q, dly1_d;
    logic [3:0]  pid_q, pid_d;

    logic        token_valid_d, sof_valid_d, hs_valid_d, data_tvalid_d;
    logic        data_end_d, data_ok_d, rx_err_d;
    logic [3:0]  token_pid_d, token_endp_d, hs_pid_d, data_pid_d;
    logic [6:0]  token_addr_d;
    logic [10:0] sof_frame_d, data_len_d;
    logic [7:0]  data_tdata_d;
    logic [2:0]  rx_err_code_d;

    logic        beat, last, phy, err;
    logic [2:0]  code;
    logic [15:0] tok_w, crc_nxt;

    assign axis_rx.tready = 1'b1;
    assign beat = axis_rx.tvalid;
    assign last = axis_rx.tlast;
    assign phy  = axis_rx.tlast & axis_rx.error;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        crc_d         = crc_q;
        tok_lo_d      = tok_lo_q;
        dly0_d        = dly0_q;
        dly1_d        = dly1_q;
        pid_d         = pid_q;
        token_valid_d = 1'b0;
        token_pid_d   = token_pid;
        token_addr_d  = token_addr;
        token_endp_d  = token_endp;
        sof_valid_d   = 1'b0;
        sof_frame_d   = sof_frame;
        hs_valid_d    = 1'b0;
        hs_pid_d      = hs_pid;
        data_tvalid_d = 1'b0;
        data_tdata_d  = data_tdata;
        data_pid_d    = data_pid;
        data_end_d    = 1'b0;
        data_ok_d     = data_ok;
        data_len_d    = data_len;
        err           = 1'b0;
        code          = 3'd0;
        tok_w         = {axis_rx.tdata, tok_lo_q};
        crc_nxt       = crc16_byte(crc_q, axis_rx.tdata);

        if (beat) begin
            unique case (state_q)
                StIdle: begin
                    pid_d = axis_rx.tdata[3:0];
                    cnt_d = 16'd0;
                    if (axis_rx.tdata[7:4] != ~axis_rx.tdata[3:0]) begin
                        err  = 1'b1;
                        code = ErrPid;
                        if (!last) state_d = StDiscard;
                    end else begin
                        unique case (axis_rx.tdata[1:0])
                            2'b01: begin
                                if (last) begin
                                    err  = 1'b1;
                                    code = ErrLen;
                                end else begin
                                    state_d = StToken;
                                end
                            end
                            2'b11: begin
                                data_pid_d = axis_rx.tdata[3:0];
                                crc_d      = 16'hFFFF;
                                if (last) begin
                                    err        = 1'b1;
                                    code       = ErrLen;
                                    data_end_d = 1'b1;
                                    data_ok_d  = 1'b0;
                                    data_len_d = 11'd0;
                                end else begin
                                    state_d = StData;
                                end
                            end
                            2'b10: begin
                                if (last) begin
                                    hs_valid_d = !phy;
                                    if (!phy) hs_pid_d = axis_rx.tdata[3:0];
                                end else begin
                                    state_d = StHshk;
                                end
                            end
                            default: begin
                                err  = 1'b1;
                                code = ErrUnsup;
                                if (!last) state_d = StDiscard;
                            end
                        endcase
                    end
                end
                StToken: begin
                    cnt_d    = cnt_q + 16'd1;
                    tok_lo_d = axis_rx.tdata;
                    if (last) state_d = StIdle;
                    if (cnt_q == 16'd0) begin
                        if (last) begin
                            err  = 1'b1;
                            code = ErrLen;
                        end
                    end else if (!last) begin
                        err     = 1'b1;
                        code    = ErrLen;
                        state_d = StDiscard;
                    end else if (crc5_word(tok_w) != Crc5Residue) begin
                        err  = 1'b1;
                        code = ErrCrc5;
                    end else if (!phy) begin
                        if (pid_q == 4'b0101) begin
                            sof_valid_d = 1'b1;
                            sof_frame_d = tok_w[10:0];
                        end else begin
                            token_valid_d = 1'b1;
                            token_pid_d   = pid_q;
                            token_addr_d  = tok_w[6:0];
                            token_endp_d  = tok_w[10:7];
                        end
                    end
                end
                StHshk: begin
                    err     = 1'b1;
                    code    = ErrLen;
                    state_d = last ? StIdle : StDiscard;
                end
                StData: begin
                    // Two-byte delay line: the trailing pair is the CRC until proven otherwise.
                    crc_d  = crc_nxt;
                    cnt_d  = cnt_q + 16'd1;
                    dly0_d = dly1_q;
                    dly1_d = axis_rx.tdata;
                    if (last) state_d = StIdle;
                    if (cnt_q >= 16'd2 && (cnt_q - 16'd2) >= MaxPay) begin
                        err  = 1'b1;
                        code = ErrLen;
                        if (last) begin
                            data_end_d = 1'b1;
                            data_ok_d  = 1'b0;
                            data_len_d = 11'(MAX_PAYLOAD);
                        end else begin
                            state_d = StDataDrop;
                        end
                    end else begin
                        if (cnt_q >= 16'd2) begin
                            data_tvalid_d = 1'b1;
                            data_tdata_d  = dly0_q;
                        end
                        if (last) begin
                            data_end_d = 1'b1;
                            if (cnt_q == 16'd0) begin
                                err        = 1'b1;
                                code       = ErrLen;
                                data_ok_d  = 1'b0;
                                data_len_d = 11'd0;
                            end else begin
                                data_len_d = 11'(cnt_q - 16'd1);
                                data_ok_d  = (crc_nxt == Crc16Residue) && !phy;
                                if (crc_nxt != Crc16Residue) begin
                                    err  = 1'b1;
                                    code = ErrCrc16;
                                end
                            end
                        end
                    end
                end
                StDataDrop: begin
                    if (last) begin
                        state_d    = StIdle;
                        data_end_d = 1'b1;
                        data_ok_d  = 1'b0;
                        data_len_d = 11'(MAX_PAYLOAD);
                    end
                end
                StDiscard: begin
                    if (last) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase

            // A PHY abort outranks whatever else this final beat revealed.
            if (phy && state_q != StDiscard && state_q != StDataDrop) begin
                err  = 1'b1;
                code = ErrPhy;
            end
        end

        rx_err_d      = err;
        rx_err_code_d = err ? code : rx_err_code;
    end

    always_ff @(posedge ulpi_clk or negedge ulpi_rst_n) begin
        if (!ulpi_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            crc_q       <= 16'hFFFF;
            tok_lo_q    <= 8'd0;
            dly0_q      <= 8'd0;
            dly1_q      <= 8'd0;
            pid_q       <= 4'd0;
            token_valid <= 1'b0;
            token_pid   <= 4'd0;
            token_addr  <= 7'd0;
            token_endp  <= 4'd0;
            sof_valid   <= 1'b0;
            sof_frame   <= 11'd0;
            hs_valid    <= 1'b0;
            hs_pid      <= 4'd0;
            data_tvalid <= 1'b0;
            data_tdata  <= 8'd0;
            data_pid    <= 4'd0;
            data_end    <= 1'b0;
            data_ok     <= 1'b0;
            data_len    <= 11'd0;
            rx_err      <= 1'b0;
            rx_err_code <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            tok_lo_q    <= tok_lo_d;
            dly0_q      <= dly0_d;
            dly1_q      <= dly1_d;
            pid_q       <= pid_d;
            token_valid <= token_valid_d;
            token_pid   <= token_pid_d;
            token_addr  <= token_addr_d;
            token_endp  <= token_endp_d;
            sof_valid   <= sof_valid_d;
            sof_frame   <= sof_frame_d;
            hs_valid    <= hs_valid_d;
            hs_pid      <= hs_pid_d;
            data_tvalid <= data_tvalid_d;
            data_tdata  <= data_tdata_d;
            data_pid    <= data_pid_d;
            data_end    <= data_end_d;
            data_ok     <= data_ok_d;
            data_len    <= data_len_d;
            rx_err      <= rx_err_d;
            rx_err_code <= rx_err_code_d;
        end
    end
endmodule

// File: tb/tb_usb_rx_pkt.sv
// Randomised packet stream checked against a packet-level reference model of the decoder.
module tb_usb_rx_pkt;
    localparam int MaxPayload = 16;
    localparam logic [3:0] KErr = 4'd1, KTok = 4'd2, KSof = 4'd3, KHs = 4'd4, KEnd = 4'd5;

    logic        ulpi_clk = 1'b0;
    logic        ulpi_rst_n;
    logic        token_valid, sof_valid, hs_valid, data_tvalid, data_end, data_ok, rx_err;
    logic [3:0]  token_pid, token_endp, hs_pid, data_pid;
    logic [6:0]  token_addr;
    logic [10:0] sof_frame, data_len;
    logic [7:0]  data_tdata;
    logic [2:0]  rx_err_code;

    usb_rx_pkt_if axis_rx ();

    usb_rx_pkt #(.MAX_PAYLOAD(MaxPayload)) dut (
        .ulpi_clk    (ulpi_clk),
        .ulpi_rst_n  (ulpi_rst_n),
        .axis_rx     (axis_rx),
        .token_valid (token_valid),
        .token_pid   (token_pid),
        .token_addr  (token_addr),
        .token_endp  (token_endp),
        .sof_valid   (sof_valid),
        .sof_frame   (sof_frame),
        .hs_valid    (hs_valid),
        .hs_pid      (hs_pid),
        .data_tvalid (data_tvalid),
        .data_tdata  (data_tdata),
        .data_pid    (data_pid),
        .data_end    (data_end),
        .data_ok     (data_ok),
        .data_len    (data_len),
        .rx_err      (rx_err),
        .rx_err_code (rx_err_code)
    );

    always #5 ulpi_clk = ~ulpi_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ev[$];
    logic [11:0] exp_db[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic [3:0] k, input logic [23:0] v);
        return {4'h0, k, v};
    endfunction

    // Reflected-register forms; the transmitted field is the complement.
    function automatic logic [4:0] crc5_ref(input logic [10:0] d);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
        return ~c;
    endfunction

    function automatic logic [15:0] crc16_ref(input logic [7:0] p[$], input int first,
                                              input int cnt);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = first; i < first + cnt; i++) begin
            c = c ^ {8'h00, p[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return ~c;
    endfunction

    // Expected outcome of a whole packet; eb is the byte index where the first error shows.
    task automatic model(input logic [7:0] p[$], input logic phy);
        int          n, eb, nemit, len;
        logic [2:0]  code;
        logic [3:0]  pid;
        logic [15:0] w;
        bit          hs, tok, sof, dend, ok;
        n = p.size(); eb = -1; nemit = 0; len = 0; code = 3'd0; pid = p[0][3:0];
        hs = 0; tok = 0; sof = 0; dend = 0; ok = 0; w = 16'h0;
        if (p[0][7:4] != ~p[0][3:0]) begin
            code = 3'd1; eb = 0;
        end else begin
            case (p[0][1:0])
                2'b00: begin code = 3'd6; eb = 0; end
                2'b10: if (n == 1) hs = 1; else begin code = 3'd4; eb = 1; end
                2'b01: begin
                    if (n != 3) begin
                        code = 3'd4; eb = (n < 3) ? n - 1 : 2;
                    end else begin
                        w = {p[2], p[1]};
                        if (w[15:11] != crc5_ref(w[10:0])) begin code = 3'd2; eb = 2; end
                        else if (pid == 4'h5) sof = 1;
                        else tok = 1;
                    end
                end
                default: begin
                    dend = 1;
                    if (n < 3) begin
                        code = 3'd4; eb = n - 1;
                    end else if (n - 3 > MaxPayload) begin
                        code = 3'd4; eb = MaxPayload + 3; nemit = MaxPayload;
                    end else begin
                        nemit = n - 3;
                        if ({p[n-1], p[n-2]} != crc16_ref(p, 1, n - 3)) begin
                            code = 3'd3; eb = n - 1;
                        end else begin
                            ok = 1; len = n - 3;
                        end
                    end
                end
            endcase
        end
        if (phy) begin
            hs = 0; tok = 0; sof = 0; ok = 0;
            if (eb < 0 || eb == n - 1) code = 3'd5;
        end
        for (int j = 0; j < nemit; j++) exp_db.push_back({pid, p[1+j]});
        if (code != 3'd0) exp_ev.push_back(ev(KErr, {21'h0, code}));
        if (tok) exp_ev.push_back(ev(KTok, {9'h0, pid, w[6:0], w[10:7]}));
        if (sof) exp_ev.push_back(ev(KSof, {13'h0, w[10:0]}));
        if (hs) exp_ev.push_back(ev(KHs, {20'h0, pid}));
        if (dend) exp_ev.push_back(ev(KEnd, {8'h0, pid, ok, ok ? 11'(len) : 11'd0}));
    endtask

    task automatic pop_ev(input string tag, input logic [31:0] obs);
        if (exp_ev.size() == 0) check({tag, "_unexpected"}, obs, 32'hFFFF_FFFF);
        else check(tag, obs, exp_ev.pop_front());
    endtask

    always @(negedge ulpi_clk) begin
        if (ulpi_rst_n) begin
            if (rx_err) pop_ev("rx_err", ev(KErr, {21'h0, rx_err_code}));
            if (token_valid) pop_ev("token", ev(KTok, {9'h0, token_pid, token_addr, token_endp}));
            if (sof_valid) pop_ev("sof", ev(KSof, {13'h0, sof_frame}));
            if (hs_valid) pop_ev("hs", ev(KHs, {20'h0, hs_pid}));
            if (data_end)
                pop_ev("data_end", ev(KEnd, {8'h0, data_pid, data_ok,
                                             data_ok ? data_len : 11'd0}));
            if (data_tvalid) begin
                if (exp_db.size() == 0)
                    check("data_unexpected", {20'h0, data_pid, data_tdata}, 32'hFFFF_FFFF);
                else check("data_byte", {20'h0, data_pid, data_tdata},
                           {20'h0, exp_db.pop_front()});
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ulpi_clk);
            axis_rx.tvalid = 1'b0;
            axis_rx.tlast  = 1'b0;
            axis_rx.error  = 1'b0;
            axis_rx.tdata  = 8'($urandom);
        end
    endtask

    task automatic send(input logic [7:0] p[$], input logic err, input bit stall);
        model(p, err);
        for (int i = 0; i < p.size(); i++) begin
            if (stall && i > 0) while ($urandom_range(0, 3) == 0) idle(1);
            @(negedge ulpi_clk);
            axis_rx.tvalid = 1'b1;
            axis_rx.tdata  = p[i];
            axis_rx.tlast  = (i == p.size() - 1);
            axis_rx.error  = err && (i == p.size() - 1);
        end
    endtask

    task automatic rand_pkt(output logic [7:0] p[$], output logic err);
        logic [3:0]  pid;
        logic [10:0] w11;
        logic [15:0] c;
        int          len, idx;
        p = {};
        case ($urandom_range(0, 3))
            0: begin
                pid = 4'({4'h2, 4'hA, 4'hE, 4'h6} >> (4 * $urandom_range(0, 3)));
                p.push_back({~pid, pid});
                if ($urandom_range(0, 7) == 0) p.push_back(8'($urandom));
            end
            1: begin
                pid = 4'({4'h1, 4'h9, 4'hD, 4'h5} >> (4 * $urandom_range(0, 3)));
                w11 = 11'($urandom);
                c   = {crc5_ref(w11), w11};
                p.push_back({~pid, pid});
                p.push_back(c[7:0]);
                p.push_back(c[15:8]);
                if ($urandom_range(0, 7) == 0) p.pop_back();
                else if ($urandom_range(0, 7) == 0) p.push_back(8'($urandom));
            end
            2: begin
                pid = 4'({4'h3, 4'hB, 4'h7, 4'hF} >> (4 * $urandom_range(0, 3)));
                len = $urandom_range(0, MaxPayload + 4);
                p.push_back({~pid, pid});
                for (int i = 0; i < len; i++) p.push_back(8'($urandom));
                c = crc16_ref(p, 1, len);
                p.push_back(c[7:0]);
                p.push_back(c[15:8]);
                if ($urandom_range(0, 5) == 0) p.pop_back();
            end
            default: begin
                len = $urandom_range(1, 5);
                for (int i = 0; i < len; i++) p.push_back(8'($urandom));
            end
        endcase
        if (p.size() > 1 && $urandom_range(0, 7) == 0) begin
            idx = $urandom_range(1, p.size() - 1);
            p[idx] = p[idx] ^ 8'(1 << $urandom_range(0, 7));
        end
        err = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        logic [7:0] pkt[$];
        logic       err;
        axis_rx.tvalid = 1'b0;
        axis_rx.tlast  = 1'b0;
        axis_rx.error  = 1'b0;
        axis_rx.tdata  = 8'h00;
        ulpi_rst_n     = 1'b0;
        repeat (3) @(negedge ulpi_clk);
        check("rst_tready", 32'(axis_rx.tready), 32'h1);
        check("rst_token_valid", 32'(token_valid), 32'h0);
        check("rst_sof_valid", 32'(sof_valid), 32'h0);
        check("rst_hs_valid", 32'(hs_valid), 32'h0);
        check("rst_data_tvalid", 32'(data_tvalid), 32'h0);
        check("rst_data_end", 32'(data_end), 32'h0);
        check("rst_rx_err", 32'(rx_err), 32'h0);
        check("rst_data_pid", 32'(data_pid), 32'h0);
        check("rst_err_code", 32'(rx_err_code), 32'h0);
        check("rst_data_len", 32'(data_len), 32'h0);
        check("rst_token_addr", 32'(token_addr), 32'h0);
        check("rst_sof_frame", 32'(sof_frame), 32'h0);
        ulpi_rst_n = 1'b1;
        idle(2);

        pkt = {8'hD2};
        send(pkt, 1'b0, 1'b0); idle(3);
        check("ack_pid", 32'(hs_pid), 32'h2);
        pkt = {8'h69, 8'h00, 8'h10};
        send(pkt, 1'b0, 1'b0); idle(3);
        check("in_pid", 32'(token_pid), 32'h9);
        check("in_addr_endp", {21'h0, token_addr, token_endp}, 32'h0);
        pkt = {8'hA5, 8'h00, 8'h10};
        send(pkt, 1'b0, 1'b0);
        pkt = {8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        send(pkt, 1'b0, 1'b0); idle(3);
        check("setup_len", 32'(data_len), 32'd8);
        check("setup_ok", 32'(data_ok), 32'h1);
        check("setup_pid", 32'(data_pid), 32'h3);
        pkt = {8'h4B, 8'h00, 8'h00};
        send(pkt, 1'b0, 1'b0);
        pkt = {8'h4B, 8'h00, 8'h01};
        send(pkt, 1'b0, 1'b0); idle(3);
        check("zlp_bad_code", 32'(rx_err_code), 32'd3);
        pkt = {8'hD3};
        send(pkt, 1'b0, 1'b0);
        pkt = {8'h69, 8'h00, 8'h11};
        send(pkt, 1'b0, 1'b0);
        pkt = {8'h69, 8'h00};
        send(pkt, 1'b0, 1'b0); idle(3);
        check("short_tok_code", 32'(rx_err_code), 32'd4);
        pkt = {8'hC3, 8'h11, 8'h22};
        send(pkt, 1'b1, 1'b0);
        pkt = {8'hD2};
        send(pkt, 1'b0, 1'b0); idle(3);

        // Reset in the middle of a token must drop it without any output.
        @(negedge ulpi_clk);
        axis_rx.tvalid = 1'b1; axis_rx.tdata = 8'h69; axis_rx.tlast = 1'b0;
        @(negedge ulpi_clk);
        axis_rx.tdata = 8'h00;
        @(negedge ulpi_clk);
        axis_rx.tvalid = 1'b0;
        ulpi_rst_n = 1'b0;
        #1;
        check("midrst_code", 32'(rx_err_code), 32'h0);
        check("midrst_hs_pid", 32'(hs_pid), 32'h0);
        idle(2);
        ulpi_rst_n = 1'b1;
        pkt = {8'h2D, 8'h00, 8'h10};
        send(pkt, 1'b0, 1'b0); idle(2);

        for (int n = 0; n < 400; n++) begin
            rand_pkt(pkt, err);
            send(pkt, err, 1'b1);
            idle($urandom_range(0, 2));
        end
        idle(6);
        check("events_left", 32'(exp_ev.size()), 32'h0);
        check("bytes_left", 32'(exp_db.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
